// File: rtl/ppu_vram_port.sv
// CPU access path into PPU memory: PPUCTRL increment, PPUADDR two-write latch and PPUDATA
// read/write. It drives VRAM, CHR ROM and palette ports from a 14-bit auto-incrementing address.
module ppu_vram_port #(
  parameter int VRAM_AW  = 11,
  parameter int INC_DOWN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               reg_en,
  input  logic               reg_we,
  input  logic [2:0]         reg_sel,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         reg_rdata,
  output logic               rdata_valid,
  output logic               ready,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [7:0]         vram_data,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  output logic [12:0]        chr_rom_addr,
  input  logic [7:0]         chr_rom_data,
  output logic [4:0]         pal_addr,
  input  logic [7:0]         pal_data,
  output logic [7:0]         pal_wdata,
  output logic               pal_we
);
  typedef enum logic {IDLE, FETCH} state_e;

  state_e      state_q, state_d;
  logic [13:0] v_q, v_d;
  logic [5:0]  t_hi_q, t_hi_d;
  logic        w_q, w_d;
  logic        inc32_q, inc32_d;
  logic [7:0]  rd_buf_q, rd_buf_d;
  logic [7:0]  reg_rdata_q, reg_rdata_d;
  logic        rdata_valid_q, rdata_valid_d;

  logic        acc, is_chr, is_pal, is_vram, wr_2007;
  logic [13:0] v_inc;
  logic        unused_pal_hi;

  assign unused_pal_hi = ^pal_data[7:6];

  assign is_chr  = ~v_q[13];
  assign is_pal  = (v_q[13:8] == 6'h3F);
  assign is_vram = v_q[13] & ~is_pal;
  // 14-bit adder wraps naturally: 3FFF+1 and 3FE0+32 both land on 0000
  assign v_inc   = v_q + (inc32_q ? 14'(INC_DOWN) : 14'd1);

  assign acc     = reg_en & clk_en & (state_q == IDLE) & ~rst;
  assign wr_2007 = acc & reg_we & (reg_sel == 3'd7);

  assign vram_addr    = v_q[VRAM_AW-1:0];
  assign chr_rom_addr = v_q[12:0];
  // Backdrop entries of the sprite palettes alias the background ones
  assign pal_addr     = (v_q[4] && v_q[1:0] == 2'b00) ? {1'b0, v_q[3:0]} : v_q[4:0];
  assign vram_wdata   = reg_wdata;
  assign pal_wdata    = reg_wdata;
  assign vram_we      = wr_2007 & is_vram;
  assign pal_we       = wr_2007 & is_pal;

  assign ready        = (state_q == IDLE);
  assign reg_rdata    = reg_rdata_q;
  assign rdata_valid  = rdata_valid_q;

  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    t_hi_d        = t_hi_q;
    w_d           = w_q;
    inc32_d       = inc32_q;
    rd_buf_d      = rd_buf_q;
    reg_rdata_d   = reg_rdata_q;
    rdata_valid_d = clk_en ? 1'b0 : rdata_valid_q;

    if (acc) begin
      case (reg_sel)
        3'd0: if (reg_we) inc32_d = reg_wdata[2];
        3'd2: if (!reg_we) w_d = 1'b0;
        3'd6: if (reg_we) begin
          if (!w_q) begin
            t_hi_d = reg_wdata[5:0];
            w_d    = 1'b1;
          end else begin
            v_d = {t_hi_q, reg_wdata};
            w_d = 1'b0;
          end
        end
        3'd7: begin
          if (reg_we) v_d = v_inc;
          else        state_d = FETCH;
        end
        default: ;
      endcase
    end

    // Memories registered the address on the accept tick, so data is ready now
    if (clk_en && state_q == FETCH) begin
      reg_rdata_d   = is_pal ? {2'b00, pal_data[5:0]} : rd_buf_q;
      rd_buf_d      = is_chr ? chr_rom_data : vram_data;
      rdata_valid_d = 1'b1;
      v_d           = v_inc;
      state_d       = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      v_q           <= '0;
      t_hi_q        <= '0;
      w_q           <= 1'b0;
      inc32_q       <= 1'b0;
      rd_buf_q      <= '0;
      reg_rdata_q   <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      v_q           <= v_d;
      t_hi_q        <= t_hi_d;
      w_q           <= w_d;
      inc32_q       <= inc32_d;
      rd_buf_q      <= rd_buf_d;
      reg_rdata_q   <= reg_rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end
endmodule
